// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 host-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Host transmit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_DEV,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  // Abort reasons reported on err_code.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_NACK  = 2'b11;

  // Common keyboard commands.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Purpose: 2-FF synchronizers for PS2_CLK/PS2_DATA plus a registered falling-edge detect on clock.
// Latency: levels 2 cycles, fall pulse 3 cycles after the pin edge.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   clk_in, data_in raw line levels
//   clk_sync        synchronized PS2_CLK level
//   data_sync       synchronized PS2_DATA level
//   fall            one-cycle pulse on a synchronized 1->0 clock transition
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to the idle-high line level so leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      data_ff  <= {data_ff[0], data_in};
      clk_prev <= clk_ff[1];
      fall     <= clk_prev & ~clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: host-to-device PS/2 transmitter; sends one command byte over the shared open-drain lines.
// Latency: clk_oe rises 1 cycle after accept; each data drive change lands 1 cycle after the sync'd clock fall.
// Backpressure: tx_ready high only in IDLE; tx_valid while not ready is ignored, nothing is queued.
//
// Ports:
//   clk, rst                     system clock, asynchronous active-low reset
//   tx_valid, tx_data, tx_ready  command byte handshake
//   busy                         high from accept until back in IDLE (decoder ignores the lines)
//   done                         one-cycle pulse after an ACKed frame, on the return to IDLE
//   err, err_code                one-cycle abort pulse; code held until the next accept
//   ps2_clk_in, ps2_data_in      raw line levels
//   ps2_clk_oe, ps2_data_oe      1 pulls the corresponding line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int START_TIMEOUT  = 1_500_000,
  parameter int FRAME_TIMEOUT  = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // The timers need at least one inhibit cycle and two cycles of timeout window.
  if (CLK_FREQ_HZ <= 0 || INHIBIT_CYCLES < 1 || START_TIMEOUT < 2 || FRAME_TIMEOUT < 2) begin : g_bad_params
    $error("ps2_host_tx: timing parameters out of range");
  end

  localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int START_W = $clog2(START_TIMEOUT + 1);
  localparam int FRAME_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]   INH_MAX    = INH_W'(INHIBIT_CYCLES);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);
  localparam logic [START_W-1:0] START_MAX  = START_W'(START_TIMEOUT);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_TIMEOUT - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX  = FRAME_W'(FRAME_TIMEOUT);

  logic clk_sync, data_sync, fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .fall      (fall)
  );

  state_t             state, state_nxt;
  logic [7:0]         cmd_q, cmd_nxt;
  logic               par_q, par_nxt;
  logic [3:0]         n_q, n_nxt;
  logic [INH_W-1:0]   inh_cnt, inh_nxt;
  logic [START_W-1:0] start_cnt, start_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_nxt;

  logic       tx_ready_q, tx_ready_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       err_q, err_nxt;
  logic [1:0] err_code_q, err_code_nxt;
  logic       clk_oe_q, clk_oe_nxt;
  logic       data_oe_q, data_oe_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cmd_q      <= '0;
      par_q      <= 1'b0;
      n_q        <= '0;
      inh_cnt    <= '0;
      start_cnt  <= '0;
      frame_cnt  <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_nxt;
      par_q      <= par_nxt;
      n_q        <= n_nxt;
      inh_cnt    <= inh_nxt;
      start_cnt  <= start_nxt;
      frame_cnt  <= frame_nxt;
      tx_ready_q <= tx_ready_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      err_code_q <= err_code_nxt;
      clk_oe_q   <= clk_oe_nxt;
      data_oe_q  <= data_oe_nxt;
    end
  end

  // Every output register is loaded from the next-state view, so the pins
  // always agree with the state the FSM is in during that cycle.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    par_nxt      = par_q;
    n_nxt        = n_q;
    inh_nxt      = inh_cnt;
    start_nxt    = start_cnt;
    frame_nxt    = frame_cnt;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = err_code_q;
    data_oe_nxt  = data_oe_q;

    case (state)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          cmd_nxt      = tx_data;
          par_nxt      = odd_parity(tx_data);
          err_code_nxt = ERR_NONE;
          n_nxt        = '0;
          inh_nxt      = '0;
          start_nxt    = '0;
          frame_nxt    = '0;
          state_nxt    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_nxt   = ST_REQ;
          data_oe_nxt = 1'b1;             // start bit
        end else if (inh_cnt != INH_MAX) begin
          inh_nxt = inh_cnt + 1'b1;
        end
      end

      // The start window opens here so that it spans REQ plus WAIT_DEV.
      ST_REQ: begin
        state_nxt = ST_WAIT_DEV;
        start_nxt = start_cnt + 1'b1;
      end

      ST_WAIT_DEV: begin
        if (start_cnt >= START_LAST) begin
          state_nxt    = ST_IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = ERR_START;
        end else if (fall) begin
          state_nxt   = ST_SHIFT;
          n_nxt       = 4'd1;
          frame_nxt   = FRAME_W'(1);
          data_oe_nxt = ~cmd_q[0];
        end else if (start_cnt != START_MAX) begin
          start_nxt = start_cnt + 1'b1;
        end
      end

      // n holds the number of falls seen; the fall that bumps it to n+1 drives bit n.
      ST_SHIFT: begin
        if (frame_cnt >= FRAME_LAST) begin
          state_nxt    = ST_IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = ERR_FRAME;
        end else begin
          if (frame_cnt != FRAME_MAX) frame_nxt = frame_cnt + 1'b1;
          if (fall) begin
            n_nxt = n_q + 4'd1;
            if (n_q <= 4'd7) begin
              data_oe_nxt = ~cmd_q[n_q[2:0]];
            end else if (n_q == 4'd8) begin
              data_oe_nxt = ~par_q;
            end else begin
              data_oe_nxt = 1'b0;         // stop bit: line floats high
              state_nxt   = ST_ACK;
            end
          end
        end
      end

      // Timeout is checked first so it wins over a coincident fall 11.
      ST_ACK: begin
        if (frame_cnt >= FRAME_LAST) begin
          state_nxt    = ST_IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = ERR_FRAME;
        end else begin
          if (frame_cnt != FRAME_MAX) frame_nxt = frame_cnt + 1'b1;
          if (fall) begin
            n_nxt = n_q + 4'd1;
            if (data_sync) begin
              state_nxt    = ST_IDLE;
              err_nxt      = 1'b1;
              err_code_nxt = ERR_NACK;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end
        end
      end

      ST_RELEASE: begin
        if (clk_sync && data_sync) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Data is only ever pulled between REQ and the stop bit.
    if (state_nxt == ST_IDLE || state_nxt == ST_INHIBIT || state_nxt == ST_RELEASE)
      data_oe_nxt = 1'b0;

    clk_oe_nxt   = (state_nxt == ST_INHIBIT) || (state_nxt == ST_REQ);
    tx_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt     = (state_nxt != ST_IDLE);
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
